conv_scheduler: RTL and testbench

- Sequences a single shared multiply-accumulate datapath over a full valid-mode 2-D convolution: KERNEL_SIZE x KERNEL_SIZE kernel over an IMGROW x IMGCOL image.
- Issues image and kernel read addresses and accumulates returned data.
- Applies activation and saturation, then streams each output pixel over a valid/ready interface.
- Sits between the image/kernel buffers and the next layer, as the time-multiplexed alternative to the fully parallel conv_layer.

---
 rtl/conv_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_conv_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_scheduler.sv
// conv_scheduler: time-multiplexed valid-mode 2-D convolution.
// One shared MAC walks the kernel window for each output pixel in raster
// order, then activates/saturates the sum and offers it on a valid/ready port.
module conv_scheduler #(
  parameter int    DATA_WIDTH  = 8,
  parameter int    KDATA_WIDTH = 8,
  parameter int    KERNEL_SIZE = 5,
  parameter int    IMGROW      = 28,
  parameter int    IMGCOL      = 28,
  parameter int    ACC_WIDTH   = 24,
  parameter int    OUT_SHIFT   = 0,
  parameter string ACTIVATION  = "RELU",
  localparam int   OROWS = IMGROW - KERNEL_SIZE + 1,
  localparam int   OCOLS = IMGCOL - KERNEL_SIZE + 1,
  localparam int   RW    = (IMGROW > 1) ? $clog2(IMGROW) : 1,
  localparam int   CW    = (IMGCOL > 1) ? $clog2(IMGCOL) : 1,
  localparam int   KW    = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1,
  localparam int   ORW   = (OROWS > 1) ? $clog2(OROWS) : 1,
  localparam int   OCW   = (OCOLS > 1) ? $clog2(OCOLS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [RW-1:0]          img_row,
  output logic [CW-1:0]          img_col,
  output logic [KW-1:0]          kern_row,
  output logic [KW-1:0]          kern_col,
  input  logic [DATA_WIDTH-1:0]  img_data,
  input  logic [KDATA_WIDTH-1:0] kern_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ORW-1:0]         out_row,
  output logic [OCW-1:0]         out_col,
  output logic [DATA_WIDTH-1:0]  out_data
);

  localparam bit IS_RELU = (ACTIVATION == "RELU");
  localparam logic signed [ACC_WIDTH-1:0] U_MAX = ACC_WIDTH'((2 ** DATA_WIDTH) - 1);
  localparam logic signed [ACC_WIDTH-1:0] S_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] S_MIN = ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT, S_DONE} state_t;

  state_t                       state;
  logic [KW-1:0]                kr, kc, kr_nxt, kc_nxt;
  logic [ORW-1:0]               orow, orow_nxt;
  logic [OCW-1:0]               ocol, ocol_nxt;
  logic                         k_last, px_last;
  logic                         data_vld;
  logic signed [ACC_WIDTH-1:0]  acc, prod, acc_sum, shifted;
  logic [DATA_WIDTH-1:0]        sat;

  // Kernel and output-pixel counter successors; both wrap at their last value.
  always_comb begin
    k_last   = (kr == KW'(KERNEL_SIZE - 1)) && (kc == KW'(KERNEL_SIZE - 1));
    px_last  = (orow == ORW'(OROWS - 1)) && (ocol == OCW'(OCOLS - 1));
    kc_nxt   = (kc == KW'(KERNEL_SIZE - 1)) ? '0 : kc + 1'b1;
    kr_nxt   = kr;
    if (kc == KW'(KERNEL_SIZE - 1))
      kr_nxt = (kr == KW'(KERNEL_SIZE - 1)) ? '0 : kr + 1'b1;
    ocol_nxt = (ocol == OCW'(OCOLS - 1)) ? '0 : ocol + 1'b1;
    orow_nxt = orow;
    if (ocol == OCW'(OCOLS - 1))
      orow_nxt = (orow == ORW'(OROWS - 1)) ? '0 : orow + 1'b1;
  end

  // MAC: unsigned pixel times signed weight, wrap-around accumulation,
  // then shift and clamp into the output range of the selected activation.
  always_comb begin
    prod    = ACC_WIDTH'(signed'({1'b0, img_data})) * ACC_WIDTH'(signed'(kern_data));
    acc_sum = acc + prod;
    shifted = acc_sum >>> OUT_SHIFT;
    sat     = shifted[DATA_WIDTH-1:0];
    if (IS_RELU) begin
      if (shifted[ACC_WIDTH-1])  sat = '0;
      else if (shifted > U_MAX)  sat = '1;
    end else begin
      if (shifted > S_MAX)       sat = S_MAX[DATA_WIDTH-1:0];
      else if (shifted < S_MIN)  sat = S_MIN[DATA_WIDTH-1:0];
    end
  end

  // Accumulator: read data lands one cycle after rd_en, so accumulation
  // trails the read strobe by one cycle; cleared at every pixel start.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      data_vld <= 1'b0;
    end else begin
      data_vld <= rd_en;
      if ((state == S_IDLE && start) || (state == S_OUT && out_ready))
        acc <= '0;
      else if (data_vld)
        acc <= acc_sum;
    end
  end

  // Sequencer with registered outputs: FETCH window, DRAIN, OUT handshake, DONE pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      img_row   <= '0;
      img_col   <= '0;
      kern_row  <= '0;
      kern_col  <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_data  <= '0;
      kr        <= '0;
      kc        <= '0;
      orow      <= '0;
      ocol      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            busy     <= 1'b1;
            rd_en    <= 1'b1;
            kr       <= '0;
            kc       <= '0;
            orow     <= '0;
            ocol     <= '0;
            img_row  <= '0;
            img_col  <= '0;
            kern_row <= '0;
            kern_col <= '0;
          end
        end
        S_FETCH: begin
          if (k_last) begin
            state <= S_DRAIN;
            rd_en <= 1'b0;
            kr    <= '0;
            kc    <= '0;
          end else begin
            kr       <= kr_nxt;
            kc       <= kc_nxt;
            img_row  <= RW'(orow) + RW'(kr_nxt);
            img_col  <= CW'(ocol) + CW'(kc_nxt);
            kern_row <= kr_nxt;
            kern_col <= kc_nxt;
          end
        end
        S_DRAIN: begin
          state     <= S_OUT;
          out_valid <= 1'b1;
          out_data  <= sat;
          out_row   <= orow;
          out_col   <= ocol;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (px_last) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              orow  <= '0;
              ocol  <= '0;
            end else begin
              state    <= S_FETCH;
              rd_en    <= 1'b1;
              orow     <= orow_nxt;
              ocol     <= ocol_nxt;
              img_row  <= RW'(orow_nxt);
              img_col  <= CW'(ocol_nxt);
              kern_row <= '0;
              kern_col <= '0;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_scheduler.sv
// tb_conv_scheduler: three scheduler variants (RELU, RELU >>2, NONE) run in
// lockstep against a cycle-timeline model and a plain-loop convolution model.
module tb_conv_scheduler;
  localparam int K = 3, R = 5, C = 5, OC = 3, P = 9, KK = 9, ND = 3;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  always #5 clk = ~clk;

  logic [ND-1:0]       rd_en, busy, done, out_valid;
  logic [ND-1:0][2:0]  img_row, img_col;
  logic [ND-1:0][1:0]  kern_row, kern_col, out_row, out_col;
  logic [ND-1:0][7:0]  out_data;

  logic [7:0] img  [R][C];
  logic [7:0] kern [K][K];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    logic [7:0] idat, kdat;
    conv_scheduler #(
      .DATA_WIDTH(8), .KDATA_WIDTH(8), .KERNEL_SIZE(K), .IMGROW(R), .IMGCOL(C),
      .ACC_WIDTH(24), .OUT_SHIFT(g == 1 ? 2 : 0), .ACTIVATION(g == 2 ? "NONE" : "RELU")
    ) u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy[g]), .done(done[g]),
      .rd_en(rd_en[g]), .img_row(img_row[g]), .img_col(img_col[g]),
      .kern_row(kern_row[g]), .kern_col(kern_col[g]),
      .img_data(idat), .kern_data(kdat),
      .out_valid(out_valid[g]), .out_ready(out_ready),
      .out_row(out_row[g]), .out_col(out_col[g]), .out_data(out_data[g])
    );
    // Buffer model: data one cycle after rd_en, garbage otherwise.
    always @(posedge clk) begin
      if (rd_en[g] && img_row[g] < 3'(R) && img_col[g] < 3'(C))
        idat <= img[img_row[g]][img_col[g]];
      else
        idat <= 8'($urandom);
      if (rd_en[g] && kern_row[g] < 2'(K) && kern_col[g] < 2'(K))
        kdat <= kern[kern_row[g]][kern_col[g]];
      else
        kdat <= 8'($urandom);
    end
  end

  int n_cmp = 0, n_err = 0;
  int cyc = 0, start_cyc = 0, done_rel = 0, n_done = 0, m_outs = 0, m_rd = 0;
  int m_pix = 0, m_t = 0;
  bit m_run = 0, m_done = 0, zchk = 0, armed = 0;
  logic [7:0] last_dat [ND];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int ish(int g);
    return (g == 1) ? 2 : 0;
  endfunction

  function automatic bit irl(int g);
    return g != 2;
  endfunction

  // Reference pixel: straight convolution sum, 24-bit wrap, shift, clamp.
  function automatic int exp_pix(int r, int c, int sh, bit relu);
    int s = 0;
    for (int a = 0; a < K; a++)
      for (int b = 0; b < K; b++)
        s += int'(img[r+a][c+b]) * int'($signed(kern[a][b]));
    s = (s <<< 8) >>> 8;
    s = s >>> sh;
    if (relu) begin
      if (s < 0) s = 0; else if (s > 255) s = 255;
    end else begin
      if (s < -128) s = -128; else if (s > 127) s = 127;
    end
    return s & 255;
  endfunction

  // Timeline model: each pixel = KK read cycles, one drain cycle, then an
  // OUT phase held until out_ready; a done cycle follows the last pixel.
  always @(negedge clk) begin
    bit ev, ov;
    ev = m_run && (m_t < KK);
    ov = m_run && (m_t >= KK + 1);
    if (armed) begin
      if (rd_en[0] === 1'b1) m_rd++;
      if (done[0] === 1'b1) begin n_done++; done_rel = cyc - start_cyc; end
      for (int g = 0; g < ND; g++) begin
        if (zchk) begin
          chk("reset_zero", 32'({rd_en[g], busy[g], done[g], out_valid[g], img_row[g], img_col[g],
                                 kern_row[g], kern_col[g], out_row[g], out_col[g], out_data[g]}), 32'd0);
        end else begin
          chk("rd_en", 32'(rd_en[g]), 32'(ev));
          chk("busy", 32'(busy[g]), 32'(m_run));
          chk("done", 32'(done[g]), 32'(m_done));
          chk("out_valid", 32'(out_valid[g]), 32'(ov));
          if (ev) begin
            chk("img_row", 32'(img_row[g]), 32'(m_pix / OC + m_t / K));
            chk("img_col", 32'(img_col[g]), 32'(m_pix % OC + m_t % K));
            chk("kern_row", 32'(kern_row[g]), 32'(m_t / K));
            chk("kern_col", 32'(kern_col[g]), 32'(m_t % K));
          end
          if (ov) begin
            chk("out_row", 32'(out_row[g]), 32'(m_pix / OC));
            chk("out_col", 32'(out_col[g]), 32'(m_pix % OC));
            chk("out_data", 32'(out_data[g]), 32'(exp_pix(m_pix / OC, m_pix % OC, ish(g), irl(g))));
          end
        end
      end
    end
    zchk = 0;
    if (rst) begin
      m_run = 0; m_done = 0; zchk = 1; armed = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_pix = 0; m_t = 0; m_outs = 0; m_rd = 0; start_cyc = cyc;
      end
    end else if (ov) begin
      if (out_ready) begin
        for (int g = 0; g < ND; g++) last_dat[g] = out_data[g];
        m_outs++;
        if (m_pix == P - 1) begin m_run = 0; m_done = 1; end
        else begin m_pix++; m_t = 0; end
      end
    end else begin
      m_t++;
    end
  end

  task automatic fill(input int iv, input int kv, input bit rnd);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        img[r][c] = rnd ? 8'($urandom) : 8'(iv);
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        kern[r][c] = rnd ? 8'($urandom) : 8'(kv);
  endtask

  // One layer: optional random backpressure, a stall at the first output,
  // an abort by reset at a given pixel, or stray start pulses.
  task automatic run_layer(input bit rnd, input int stall_n, input int abort_px, input bit spur);
    int stalled = 0, t = 0;
    bit fin = 0, ab = 0;
    n_done = 0;
    @(posedge clk); #1; start = 1; out_ready = 1;
    @(posedge clk); #1; start = 0;
    while (!fin) begin
      rst = 0;
      if (abort_px >= 0 && !ab && m_pix == abort_px && rd_en[0]) begin
        rst = 1; ab = 1;
      end else if (ab) begin
        fin = 1;
      end
      if (out_valid[0] && stalled < stall_n) begin
        out_ready = 0; stalled++;
      end else begin
        out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      start = spur && ((rd_en[0] && $urandom_range(0, 3) == 0) || out_valid[0] || done[0]);
      if (done[0]) fin = 1;
      t++;
      if (t > 3000) begin
        n_cmp++; n_err++;
        $display("FAIL layer_timeout: got no done after %0d cycles, required done", t);
        fin = 1;
      end
      @(posedge clk); #1;
    end
    start = 0; rst = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pin3(input string tag, input int e0, input int e1, input int e2);
    chk({tag, "_relu"}, 32'(last_dat[0]), 32'(e0));
    chk({tag, "_relu_sh2"}, 32'(last_dat[1]), 32'(e1));
    chk({tag, "_none"}, 32'(last_dat[2]), 32'(e2));
  endtask

  task automatic pin_layer(input string tag, input int drel);
    chk({tag, "_done_cycle"}, 32'(done_rel), 32'(drel));
    chk({tag, "_outputs"}, 32'(m_outs), 32'(P));
    chk({tag, "_done_pulses"}, 32'(n_done), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1; start = 0; out_ready = 1;
    fill(0, 0, 0);
    repeat (3) @(posedge clk);
    #1; rst = 0;
    @(posedge clk); #1;

    fill(1, 1, 0);
    run_layer(0, 0, -1, 0);
    pin_layer("s1", 100);
    chk("s1_rd_cycles", 32'(m_rd), 32'd81);
    pin3("s1", 9, 2, 9);

    fill(10, 8'hFF, 0);
    run_layer(0, 0, -1, 0);
    pin3("s2", 0, 0, 8'hA6);

    fill(255, 8'h7F, 0);
    run_layer(0, 0, -1, 0);
    pin3("s3_sat", 255, 255, 127);
    fill(255, 1, 0);
    run_layer(0, 0, -1, 0);
    pin3("s3_k1", 255, 255, 127);
    fill(4, 1, 0);
    run_layer(0, 0, -1, 0);
    pin3("s3_img4", 36, 9, 36);

    fill(1, 1, 0);
    run_layer(0, 5, -1, 0);
    pin_layer("s4", 105);
    pin3("s4", 9, 2, 9);

    run_layer(0, 0, 3, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("s5_no_done", 32'(n_done), 32'd0);
    chk("s5_idle", 32'({busy, out_valid, rd_en}), 32'd0);
    run_layer(0, 0, -1, 0);
    pin_layer("s5_restart", 100);
    pin3("s5_restart", 9, 2, 9);

    run_layer(0, 0, -1, 1);
    pin_layer("s6", 100);

    for (int i = 0; i < 4; i++) begin
      fill(0, 0, 1);
      run_layer(1, (i == 0) ? 3 : 0, -1, 0);
      chk("rand_outputs", 32'(m_outs), 32'(P));
      chk("rand_done_pulses", 32'(n_done), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
